// File: rtl/iterative_shift_unit_pkg.sv
// Shared constants for the iterative shift unit: operation codes and FSM state encoding.
// The reserved op code (2'b10) has no name; it falls through to the left-shift path.
package iterative_shift_unit_pkg;

  localparam int ADDR_WIDTH = 32;

  localparam logic [1:0] SHIFT_OP_SLL = 2'b00;
  localparam logic [1:0] SHIFT_OP_SRL = 2'b01;
  localparam logic [1:0] SHIFT_OP_SRA = 2'b11;

  typedef enum logic [1:0] {
    SHU_IDLE  = 2'd0,
    SHU_SHIFT = 2'd1,
    SHU_DONE  = 2'd2
  } shu_state_e;

endpackage

// File: rtl/iterative_shift_unit_if.sv
// Request/response bundle of the iterative shift unit plus its flush and busy side-band.
// master = pipeline side issuing requests and consuming results; slave = the shift unit.
interface iterative_shift_unit_if #(
  parameter int DATA_W  = iterative_shift_unit_pkg::ADDR_WIDTH,
  parameter int SHAMT_W = 5
);

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         op;
  logic [DATA_W-1:0]  data_in;
  logic [SHAMT_W-1:0] shamt;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  data_out;
  logic               busy;

  modport master (
    output flush, in_valid, op, data_in, shamt, out_ready,
    input  in_ready, out_valid, data_out, busy
  );

  modport slave (
    input  flush, in_valid, op, data_in, shamt, out_ready,
    output in_ready, out_valid, data_out, busy
  );

endinterface

// File: rtl/iterative_shift_unit_shift_step.sv
// One-bit shift of the accumulator; purely combinational, zero latency, no handshake.
// Kept separate so direction/fill selection can be replicated for multi-bit-per-cycle variants.
module iterative_shift_unit_shift_step
  import iterative_shift_unit_pkg::*;
#(
  parameter int DATA_W = ADDR_WIDTH
) (
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_acc,
  output logic [DATA_W-1:0] o_acc
);

  always_comb begin
    o_acc = {i_acc[DATA_W-2:0], 1'b0};
    case (i_op)
      SHIFT_OP_SRL: o_acc = {1'b0, i_acc[DATA_W-1:1]};
      // The MSB is never overwritten, so replicating it keeps the operand's original sign.
      SHIFT_OP_SRA: o_acc = {i_acc[DATA_W-1], i_acc[DATA_W-1:1]};
      default:      ;
    endcase
  end

endmodule

// File: rtl/iterative_shift_unit.sv
// SLL/SRL/SRA at one bit per cycle; result valid shamt+1 cycles after acceptance.
// Result is held in DONE until out_ready; no new request is taken until the result leaves.
module iterative_shift_unit
  import iterative_shift_unit_pkg::*;
#(
  parameter int DATA_W  = ADDR_WIDTH,
  parameter int SHAMT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  iterative_shift_unit_if.slave bus
);

  shu_state_e         r_state;
  shu_state_e         w_state_nxt;
  logic [DATA_W-1:0]  r_acc;
  logic [DATA_W-1:0]  w_acc_nxt;
  logic [DATA_W-1:0]  w_acc_step;
  logic [DATA_W-1:0]  r_data_out;
  logic [SHAMT_W-1:0] r_cnt;
  logic [SHAMT_W-1:0] w_cnt_nxt;
  logic [1:0]         r_op;
  logic [1:0]         w_op_nxt;
  logic               r_out_valid;
  logic               r_busy;
  logic               w_accept;

  iterative_shift_unit_shift_step #(
    .DATA_W (DATA_W)
  ) u_shift_step (
    .i_op  (r_op),
    .i_acc (r_acc),
    .o_acc (w_acc_step)
  );

  // in_ready depends only on state and reset; a flush in the same cycle vetoes the accept instead.
  assign bus.in_ready  = rst_n && (r_state == SHU_IDLE);
  assign w_accept      = bus.in_valid && bus.in_ready && !bus.flush;
  assign bus.out_valid = r_out_valid;
  assign bus.data_out  = r_data_out;
  assign bus.busy      = r_busy;

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;

    case (r_state)
      SHU_IDLE: begin
        if (w_accept) begin
          w_acc_nxt   = bus.data_in;
          w_op_nxt    = bus.op;
          w_cnt_nxt   = bus.shamt;
          w_state_nxt = (bus.shamt == '0) ? SHU_DONE : SHU_SHIFT;
        end
      end
      SHU_SHIFT: begin
        w_acc_nxt = w_acc_step;
        w_cnt_nxt = r_cnt - SHAMT_W'(1);
        if (r_cnt == SHAMT_W'(1)) begin
          w_state_nxt = SHU_DONE;
        end
      end
      SHU_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = SHU_IDLE;
        end
      end
      default: w_state_nxt = SHU_IDLE;
    endcase

    if (bus.flush) begin
      w_state_nxt = SHU_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= SHU_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_op        <= SHIFT_OP_SLL;
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_op        <= w_op_nxt;
      r_out_valid <= (w_state_nxt == SHU_DONE);
      r_busy      <= (w_state_nxt != SHU_IDLE);
      // acc does not move in DONE, so reloading here keeps data_out stable while stalled.
      if (w_state_nxt == SHU_DONE) begin
        r_data_out <= w_acc_nxt;
      end
    end
  end

endmodule

// File: doc/iterative_shift_unit.md
# iterative_shift_unit

Multi-cycle shift unit for the execute stage that handles the RV32I shifts, SLL, SRL and SRA. Left shift is its primary new function; it complements the existing combinational sign-extended right-shift path. The unit shifts one bit position per cycle, which keeps area and timing small. It uses a valid/ready handshake on both sides so the pipeline can stall around it, and it supports a synchronous flush for branch mispredict or trap.

## Interface
Parameters:
- DATA_W, default `ADDR_WIDTH (32): operand and result width.
- SHAMT_W, default 5: shift-amount width, equal to log2(DATA_W).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- flush  in  1  synchronous abort; discards any in-flight operation.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request.
- op  in  2  shift operation: 00 = SLL, 01 = SRL, 11 = SRA, 10 = reserved (executes as SLL).
- data_in  in  DATA_W  operand.
- shamt  in  SHAMT_W  shift amount, 0..DATA_W-1.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- data_out  out  DATA_W  result; registered.
- busy  out  1  high in SHIFT or DONE.

## Operation
- State machine states:
  - IDLE: in_ready = 1. On in_valid: latch data_in into acc, latch op, set cnt = shamt. Go to DONE if shamt == 0, otherwise go to SHIFT.
  - SHIFT: each cycle, update acc and decrement cnt:
    - SLL: acc = {acc[DATA_W-2:0], 1'b0}.
    - SRL: acc = {1'b0, acc[DATA_W-1:1]}.
    - SRA: acc = {acc[DATA_W-1], acc[DATA_W-1:1]}.
    - When cnt == 1, the shift still happens and the state goes to DONE.
  - DONE: out_valid = 1 and data_out = acc, both held stable. On out_ready, go to IDLE.
- in_ready is asserted only in IDLE and with rst_n high. There is no overlap of a new request with DONE.
- SRA sign is acc[DATA_W-1] at each step. Because the sign bit is preserved, this equals the original operand's sign.
- Only the low SHAMT_W bits of shamt are used; no modulo logic is needed beyond that.
- flush has priority over every other input. The next state is IDLE, out_valid drops, and the pending result is lost.
  - flush in IDLE while in_valid is high: the request is not accepted.
  - flush in DONE at the same cycle as out_ready: the result counts as consumed. The consumer may sample it; the state still ends in IDLE.
- Reset (rst_n = 0 at a clock edge), from any state, including mid-shift:
  - state = IDLE, acc = 0, cnt = 0, op = SLL.
  - out_valid = 0, data_out = 0, busy = 0.
  - in_ready = 0 while rst_n is low.

## Timing
- A request is accepted at edge T, in IDLE with in_valid and in_ready both high.
- out_valid rises after edge T+1+shamt. For shamt = 0, out_valid is high in the cycle after acceptance.
- Minimum issue interval: shamt + 2 cycles, with out_ready tied high.
- data_out, out_valid and busy are registers. in_ready is combinational from the state and rst_n only, never from in_valid.
- The result is held indefinitely while out_ready is low.

## Structure
- Add to the shared header system_param.vh:
  - `SHIFT_OP_SLL, `SHIFT_OP_SRL, `SHIFT_OP_SRA.
  - State encodings `SHU_IDLE, `SHU_SHIFT, `SHU_DONE.
- One combinational sub-module, shift_step (inputs op and acc; output the one-bit-shifted acc). It isolates the direction and fill logic and is reusable if the unit is widened to multiple bits per cycle.
- Top-level iterative_shift_unit contains the state register, acc, cnt, and the handshake logic.

## Test plan
- SLL, data_in = 0x0000_0001, shamt = 31 → data_out = 0x8000_0000, out_valid at T+32.
- SRA, data_in = 0x8000_0000, shamt = 4 → 0xF800_0000 at T+5. SRL with the same inputs → 0x0800_0000.
- shamt = 0, op = SRA, data_in = 0xDEAD_BEEF → 0xDEAD_BEEF at T+1.
- Hold test: out_ready low for 10 cycles in DONE → data_out and out_valid stay stable, and in_ready stays 0. Release out_ready → IDLE next cycle.
- flush at T+3 of an SLL with shamt = 20 → IDLE next cycle, out_valid never rises. The next request, SLL 0x3 by 2, returns 0xC.
- rst_n low mid-SRA, plus op = 10 with 0x1 by 1 → all outputs 0 and IDLE. The reserved op returns 0x2.
